// File: rtl/stall_control_pkg.sv
// Shared pipeline decode definitions.
// Holds the opcode/funct field helpers and constants, the instruction-class
// decode functions, and the write-register / Tuse / Tnew functions.
// The stall unit and the forwarding unit both import this package.
// No ports; this file is a package only.
package pipeline_defs;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef logic [4:0] reg_t;
    typedef logic [1:0] tval_t;

    // Tuse value for a field that is never read. It is larger than any
    // Tnew (max 2), so "tuse < tnew" can never hold for it.
    localparam tval_t TUSE_NONE = 2'd3;

    // Field extraction
    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction
    function automatic reg_t f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction
    function automatic reg_t f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction
    function automatic reg_t f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction
    function automatic logic [5:0] f_funct(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    // Instruction classes
    function automatic logic is_special(input logic [31:0] ir);
        return f_op(ir) == OP_SPECIAL;
    endfunction
    function automatic logic is_load(input logic [31:0] ir);
        return f_op(ir) inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(input logic [31:0] ir);
        return f_op(ir) inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic is_rcal(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_ADD, FN_ADDU, FN_SUB,
               FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR});
    endfunction
    function automatic logic is_ical(input logic [31:0] ir);
        return f_op(ir) inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI};
    endfunction
    function automatic logic is_lui(input logic [31:0] ir);
        return f_op(ir) == OP_LUI;
    endfunction
    // The all-zero word is the nop, not an sll.
    function automatic logic is_shift_imm(input logic [31:0] ir);
        return is_special(ir) && (ir != '0) &&
               (f_funct(ir) inside {FN_SLL, FN_SRL, FN_SRA});
    endfunction
    function automatic logic is_shift_var(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_SLLV, FN_SRLV, FN_SRAV});
    endfunction
    function automatic logic is_shift(input logic [31:0] ir);
        return is_shift_imm(ir) || is_shift_var(ir);
    endfunction
    function automatic logic is_set_r(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_SLT, FN_SLTU});
    endfunction
    function automatic logic is_set_i(input logic [31:0] ir);
        return f_op(ir) inside {OP_SLTI, OP_SLTIU};
    endfunction
    function automatic logic is_br_rs_rt(input logic [31:0] ir);
        return f_op(ir) inside {OP_BEQ, OP_BNE};
    endfunction
    // blez, bgtz, and the REGIMM pair bltz (rt=0) / bgez (rt=1)
    function automatic logic is_br_rs(input logic [31:0] ir);
        return (f_op(ir) inside {OP_BLEZ, OP_BGTZ}) ||
               (f_op(ir) == OP_REGIMM && f_rt(ir)[4:1] == 4'd0);
    endfunction
    function automatic logic is_jr(input logic [31:0] ir);
        return is_special(ir) && f_funct(ir) == FN_JR;
    endfunction
    function automatic logic is_jalr(input logic [31:0] ir);
        return is_special(ir) && f_funct(ir) == FN_JALR;
    endfunction
    function automatic logic is_jal(input logic [31:0] ir);
        return f_op(ir) == OP_JAL;
    endfunction
    function automatic logic is_md(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction
    function automatic logic is_div(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_DIV, FN_DIVU});
    endfunction
    function automatic logic is_mf(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_MFHI, FN_MFLO});
    endfunction
    function automatic logic is_mt(input logic [31:0] ir);
        return is_special(ir) && (f_funct(ir) inside {FN_MTHI, FN_MTLO});
    endfunction
    // Anything that touches HI/LO or the mult/div unit
    function automatic logic is_hilo_user(input logic [31:0] ir);
        return is_md(ir) || is_mf(ir) || is_mt(ir);
    endfunction

    // Stage (relative to D) at which the rs / rt value is first needed
    function automatic tval_t tuse_rs(input logic [31:0] ir);
        if (is_br_rs_rt(ir) || is_br_rs(ir) || is_jr(ir) || is_jalr(ir))
            return 2'd0;
        if (is_load(ir) || is_store(ir) || is_rcal(ir) || is_ical(ir) ||
            is_shift_var(ir) || is_set_r(ir) || is_set_i(ir) ||
            is_md(ir) || is_mt(ir))
            return 2'd1;
        return TUSE_NONE;
    endfunction

    function automatic tval_t tuse_rt(input logic [31:0] ir);
        if (is_br_rs_rt(ir))
            return 2'd0;
        if (is_rcal(ir) || is_shift(ir) || is_set_r(ir) || is_md(ir))
            return 2'd1;
        if (is_store(ir))
            return 2'd2;
        return TUSE_NONE;
    endfunction

    // Cycles until the result is available, for a producer sitting in E / M
    function automatic tval_t tnew_e(input logic [31:0] ir);
        if (is_load(ir))
            return 2'd2;
        if (is_rcal(ir) || is_ical(ir) || is_lui(ir) || is_shift(ir) ||
            is_set_r(ir) || is_set_i(ir) || is_mf(ir))
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic tval_t tnew_m(input logic [31:0] ir);
        return is_load(ir) ? 2'd1 : 2'd0;
    endfunction

    // Destination register; 0 means "writes nothing"
    function automatic reg_t wreg(input logic [31:0] ir);
        if (is_rcal(ir) || is_shift(ir) || is_set_r(ir) || is_mf(ir) || is_jalr(ir))
            return f_rd(ir);
        if (is_jal(ir))
            return 5'd31;
        if (is_ical(ir) || is_lui(ir) || is_set_i(ir) || is_load(ir))
            return f_rt(ir);
        return 5'd0;
    endfunction

    // One source against one producer: stall when the value is not ready in time
    function automatic logic raw_hazard(input reg_t src, input tval_t tuse,
                                        input reg_t wr, input tval_t tnew);
        return (src != 5'd0) && (src == wr) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/stall_control_if.sv
// Pipeline-side bundle of the stall unit.
//   IR_D/IR_E/IR_M : instruction words in decode / execute / memory
//   stall          : freeze PC and IR_D, bubble into IR_E
//   md_start       : mult/div instruction is in E this cycle
//   md_busy        : mult/div unit counter nonzero
//   stall_cycles   : saturating count of stalled cycles
// master = pipeline (drives IRs), slave = stall_control.
interface stall_control_if;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic [31:0] IR_M;
    logic        stall;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output IR_D, IR_E, IR_M,
        input  stall, md_start, md_busy, stall_cycles
    );

    modport slave (
        input  IR_D, IR_E, IR_M,
        output stall, md_start, md_busy, stall_cycles
    );
endinterface

// File: rtl/stall_control_md_busy_counter.sv
// Mult/div busy counter.
//   clk, rst_n : clock, async active-low reset
//   load       : a mult/div is leaving E on this edge
//   load_val   : busy length for that operation
//   busy       : counter is nonzero
// A load overrides the decrement, so back-to-back mult/div operations
// restart the count from the new operation's length.
module md_busy_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       busy
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign busy = (cnt != 4'd0);
endmodule

// File: rtl/stall_control.sv
// Hazard-detection / stall unit beside D-stage decode.
// Stalls when forwarding cannot deliver an operand by its use stage, and
// holds HI/LO consumers in D while the mult/div unit is busy.
//   clk, rst_n : clock, async active-low reset
//   bus        : IR_D/IR_E/IR_M in; stall, md_start, md_busy,
//                stall_cycles out (see stall_control_if)
// MULT_CYCLES / DIV_CYCLES (1..15): busy cycles after the op leaves E.
module stall_control
    import pipeline_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    stall_control_if.slave  bus
);
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    // D-stage consumer
    reg_t  rs_d, rt_d;
    tval_t tuse_rs_d, tuse_rt_d;
    // E and M producers
    reg_t  wr_e, wr_m;
    tval_t tn_e, tn_m;

    logic data_stall, md_stall, stall;
    logic md_start, md_busy;
    logic [31:0] stall_cnt;

    assign rs_d      = f_rs(bus.IR_D);
    assign rt_d      = f_rt(bus.IR_D);
    assign tuse_rs_d = tuse_rs(bus.IR_D);
    assign tuse_rt_d = tuse_rt(bus.IR_D);
    assign wr_e      = wreg(bus.IR_E);
    assign wr_m      = wreg(bus.IR_M);
    assign tn_e      = tnew_e(bus.IR_E);
    assign tn_m      = tnew_m(bus.IR_M);

    // rs and rt are checked independently against both producers
    assign data_stall = raw_hazard(rs_d, tuse_rs_d, wr_e, tn_e) |
                        raw_hazard(rt_d, tuse_rt_d, wr_e, tn_e) |
                        raw_hazard(rs_d, tuse_rs_d, wr_m, tn_m) |
                        raw_hazard(rt_d, tuse_rt_d, wr_m, tn_m);

    assign md_start = is_md(bus.IR_E);

    md_busy_counter u_md_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_start),
        .load_val (is_div(bus.IR_E) ? DIV_LD : MULT_LD),
        .busy     (md_busy)
    );

    // md_start is included so a HI/LO user directly behind the mult/div
    // is held in the cycle before the counter has been loaded.
    assign md_stall = is_hilo_user(bus.IR_D) & (md_start | md_busy);
    assign stall    = data_stall | md_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 32'd0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall        = stall;
    assign bus.md_start     = md_start;
    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_stall_control.sv
module tb_stall_control;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int NONE   = 99;

    logic clk;
    logic rst_n;
    stall_control_if bus();

    stall_control #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: cycle index and the cycle at which the
    // mult/div unit becomes free again (busy while cyc < md_done).
    int          cyc     = 0;
    int          md_done = 0;
    logic [31:0] sc      = 0;

    // One row per mnemonic, straight from the Tuse/Tnew/write-register tables.
    task automatic ref_info(input logic [31:0] ir,
                            output int use_rs, output int use_rt,
                            output int te, output int tm, output int wr,
                            output bit md, output bit hilo, output bit dv);
        logic [5:0] op, fn;
        int rt, rd;
        op = ir[31:26]; fn = ir[5:0];
        rt = int'(ir[20:16]); rd = int'(ir[15:11]);
        use_rs = NONE; use_rt = NONE; te = 0; tm = 0; wr = 0;
        md = 0; hilo = 0; dv = 0;
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03: if (ir != 0) begin use_rt = 1; te = 1; wr = rd; end
                6'h04, 6'h06, 6'h07: begin use_rs = 1; use_rt = 1; te = 1; wr = rd; end
                6'h08: use_rs = 0;
                6'h09: begin use_rs = 0; wr = rd; end
                6'h10, 6'h12: begin te = 1; wr = rd; hilo = 1; end
                6'h11, 6'h13: begin use_rs = 1; hilo = 1; end
                6'h18, 6'h19: begin use_rs = 1; use_rt = 1; md = 1; hilo = 1; end
                6'h1A, 6'h1B: begin use_rs = 1; use_rt = 1; md = 1; hilo = 1; dv = 1; end
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: begin use_rs = 1; use_rt = 1; te = 1; wr = rd; end
                default: ;
            endcase
            6'h01: if (rt <= 1) use_rs = 0;
            6'h03: wr = 31;
            6'h04, 6'h05: begin use_rs = 0; use_rt = 0; end
            6'h06, 6'h07: use_rs = 0;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E:
                begin use_rs = 1; te = 1; wr = rt; end
            6'h0F: begin te = 1; wr = rt; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                begin use_rs = 1; te = 2; tm = 1; wr = rt; end
            6'h28, 6'h29, 6'h2B: begin use_rs = 1; use_rt = 2; end
            default: ;
        endcase
    endtask

    function automatic bit hz(int src, int use_t, int wr, int tn);
        return src != 0 && src == wr && use_t < tn;
    endfunction

    // Expected outputs for the inputs currently on the bus
    task automatic model_eval(output bit exp_stall, output bit exp_start,
                              output bit exp_busy, output int ld);
        int urs, urt, te, tm, wr, x1, x2, x3, x4, wre, tee, wrm, tmm;
        bit mdd, hd, dvd, mde, he, dve, mdm, hm, dvm;
        int rs, rt;
        ref_info(bus.IR_D, urs, urt, x1, x2, x3, mdd, hd, dvd);
        ref_info(bus.IR_E, x1, x2, tee, x4, wre, mde, he, dve);
        ref_info(bus.IR_M, x1, x2, te, tmm, wrm, mdm, hm, dvm);
        rs = int'(bus.IR_D[25:21]); rt = int'(bus.IR_D[20:16]);
        exp_start = mde;
        exp_busy  = cyc < md_done;
        ld        = dve ? DIV_N : MULT_N;
        exp_stall = hz(rs, urs, wre, tee) || hz(rt, urt, wre, tee) ||
                    hz(rs, urs, wrm, tmm) || hz(rt, urt, wrm, tmm) ||
                    (hd && (exp_start || exp_busy));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit s, st, b; int ld;
        model_eval(s, st, b, ld);
        check({tag, ".stall"},    32'(bus.stall),    32'(s));
        check({tag, ".md_start"}, 32'(bus.md_start), 32'(st));
        check({tag, ".md_busy"},  32'(bus.md_busy),  32'(b));
        check({tag, ".cycles"},   bus.stall_cycles,  sc);
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        bus.IR_D = d; bus.IR_E = e; bus.IR_M = m;
        #1;
    endtask

    // Advance one rising edge, updating the model with the pre-edge inputs
    task automatic step();
        bit s, st, b; int ld;
        model_eval(s, st, b, ld);
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (st) md_done = cyc + ld;
            if (s && sc != 32'hFFFF_FFFF) sc++;
        end
        #1;
    endtask

    localparam logic [31:0] LW8   = 32'h8E080000;
    localparam logic [31:0] ADD9  = 32'h01084820;
    localparam logic [31:0] MULT  = 32'h01090018;
    localparam logic [31:0] DIV   = 32'h0109001A;
    localparam logic [31:0] MFLO  = 32'h00005012;

    logic [31:0] pool [35] = '{
        32'h00000020, 32'h00000021, 32'h00000022, 32'h00000024, 32'h00000025,
        32'h0000002A, 32'h0000002B, 32'h00000000, 32'h00000002, 32'h00000004,
        32'h00000008, 32'h00000009, 32'h00000010, 32'h00000012, 32'h00000011,
        32'h00000013, 32'h00000018, 32'h00000019, 32'h0000001A, 32'h0000001B,
        32'h20000000, 32'h34000000, 32'h3C000000, 32'h28000000, 32'h8C000000,
        32'h80000000, 32'hAC000000, 32'hA0000000, 32'h10000000, 32'h14000000,
        32'h18000000, 32'h1C000000, 32'h0C000000, 32'h08000000, 32'h00000000};
    int regs [5] = '{0, 8, 9, 10, 31};

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        if ($urandom_range(0, 9) == 0) return 32'h0;
        ir = pool[$urandom_range(0, 34)];
        ir[25:21] = 5'(regs[$urandom_range(0, 4)]);
        ir[20:16] = 5'(regs[$urandom_range(0, 4)]);
        ir[15:11] = 5'(regs[$urandom_range(0, 4)]);
        return ir;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        // Reset state
        check("rst.busy",   32'(bus.md_busy), 32'd0);
        check("rst.cycles", bus.stall_cycles, 32'd0);
        check("rst.stall",  32'(bus.stall),   32'd0);
        // Combinational paths are live during reset
        drive(ADD9, LW8, 0);
        check("rst.comb_stall", 32'(bus.stall), 32'd1);
        drive(0, MULT, 0);
        check("rst.comb_start", 32'(bus.md_start), 32'd1);
        drive(0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use
        drive(ADD9, LW8, 0);
        check("ldu.stall", 32'(bus.stall), 32'd1); check_model("ldu0");
        step();
        drive(ADD9, 0, LW8);
        check("ldu.stall_m", 32'(bus.stall), 32'd0);
        check("ldu.cycles", bus.stall_cycles, 32'd1); check_model("ldu1");
        step();

        // Store data vs. load base
        drive(32'hAE080000, LW8, 0);
        check("st.stall", 32'(bus.stall), 32'd0); check_model("st");
        step();
        drive(32'h8D080000, LW8, 0);
        check("ldbase.stall", 32'(bus.stall), 32'd1); check_model("ldbase");
        step();

        // Branch, Tuse 0
        drive(32'h11000003, 32'h00004021, 0);
        check("br.e", 32'(bus.stall), 32'd1); check_model("br_e");
        step();
        drive(32'h11000003, 0, LW8);
        check("br.m_load", 32'(bus.stall), 32'd1); check_model("br_ml");
        step();
        drive(32'h11000003, 0, 32'h00004021);
        check("br.m_alu", 32'(bus.stall), 32'd0); check_model("br_ma");
        step();

        // $0 writer and nop in D
        drive(32'h00004820, 32'h8E000000, 0);
        check("zero.stall", 32'(bus.stall), 32'd0); check_model("zero");
        step();
        drive(0, LW8, LW8);
        check("nop.stall", 32'(bus.stall), 32'd0); check_model("nop");
        step();

        // Mult busy window
        drive(MFLO, MULT, 0);
        check("mult.start", 32'(bus.md_start), 32'd1);
        check("mult.stall_t", 32'(bus.stall), 32'd1); check_model("mult_t");
        step();
        for (int k = 1; k <= MULT_N; k++) begin
            drive(MFLO, 0, 0);
            check($sformatf("mult.busy_t%0d", k), 32'(bus.md_busy), 32'd1);
            check($sformatf("mult.stall_t%0d", k), 32'(bus.stall), 32'd1);
            step();
        end
        drive(MFLO, 0, 0);
        check("mult.done_stall", 32'(bus.stall), 32'd0);
        check("mult.done_busy", 32'(bus.md_busy), 32'd0); check_model("mult_done");
        step();

        // Div busy window
        drive(MFLO, DIV, 0);
        check("div.stall_t", 32'(bus.stall), 32'd1);
        step();
        for (int k = 1; k <= DIV_N; k++) begin
            drive(MFLO, 0, 0);
            check($sformatf("div.stall_t%0d", k), 32'(bus.stall), 32'd1);
            step();
        end
        drive(MFLO, 0, 0);
        check("div.done_stall", 32'(bus.stall), 32'd0); check_model("div_done");
        step();

        // Reset in the middle of a divide (counter at 7)
        drive(0, DIV, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0);
            step();
        end
        check("midrst.busy_before", 32'(bus.md_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        md_done = cyc; sc = 0;
        check("midrst.busy",   32'(bus.md_busy), 32'd0);
        check("midrst.cycles", bus.stall_cycles, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(MFLO, 0, 0);
        check("midrst.mflo", 32'(bus.stall), 32'd0); check_model("midrst");
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(rand_ir(), rand_ir(), rand_ir());
            check_model($sformatf("rnd%0d", i));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stall_control.md
Name: stall_control

Overview:
- Hazard-detection counterpart to the pipeline forwarding logic.
- Where forwarding cannot deliver an operand by its use stage, this block stalls the pipeline: freeze PC and IR_D, insert a bubble into IR_E.
- Owns a multi-cycle mult/div busy counter that holds HI/LO consumers in D.
- Sits beside the D-stage decode. Consumes IR_D, IR_E and IR_M; drives the stall line to the PC, IR_D and IR_E registers.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E (1..15)
- DIV_CYCLES, 10, busy cycles after div/divu leaves E (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IR_D  in  32  instruction in decode
- IR_E  in  32  instruction in execute
- IR_M  in  32  instruction in memory
- stall  out  1  freeze PC/IR_D, clear IR_E next edge
- md_start  out  1  mult/multu/div/divu present in E this cycle
- md_busy  out  1  mult/div unit busy (counter != 0)
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): md counter = 0, stall_cycles = 0. md_busy = 0 immediately. md_start and stall become purely combinational from the IR inputs.
- IR_E always holds an instruction for exactly one cycle; stall inserts a bubble (0x00000000) and never freezes E.

Tuse (D consumer):
- rs, Tuse 0: beq, bne, blez, bgtz, bltz, bgez, jr, jalr.
- rs, Tuse 1: load/store base, R-cal, I-cal, sllv/srlv/srav, slt/slti/sltiu/sltu, mult/multu/div/divu, mthi/mtlo.
- rt, Tuse 0: beq, bne.
- rt, Tuse 1: R-cal, all shifts, slt/sltu, mult/multu/div/divu.
- rt, Tuse 2: sb, sh, sw.
- Any other field: not read; never stalls.

Tnew (producer):
- In E: loads 2; R-cal, I-cal, lui, shifts, set, mfhi/mflo 1; jal/jalr 0.
- In M: loads 1; everything else 0.

Write register:
- rd for R-cal, shifts, slt/sltu, mfhi/mflo, jalr.
- 31 for jal.
- rt for I-cal, lui, slti/sltiu, loads.
- 0 for all else (stores, branches, muldiv, mt*, nop).

Data-hazard stall:
- Condition: src == write-reg, src != 0, and Tuse < Tnew; evaluated for E and M producers, for rs and rt independently.
- $0 never stalls.

Mult/div counter (4-bit):
- On the edge ending a cycle with md_start=1: load MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
- Otherwise decrement if nonzero; hold at 0.
- A load always wins over a decrement.

Mult/div stall:
- IR_D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo AND (md_start | md_busy).

Output combination:
- stall = data-hazard stall OR mult/div stall.
- stall_cycles increments on every edge with stall=1 and saturates at 0xFFFFFFFF.

Boundary cases:
- Reset mid-busy aborts the operation; there is no pending state.
- IR_D = 0 (nop) never stalls.
- sll with IR != 0 is treated as a shift.

Decomposition:
- Shared package (pipeline_defs):
  - op/funct field ranges and the opcode/funct constants;
  - instruction-class decode functions (is_load, is_rcal, ...), write-register and Tuse/Tnew functions.
  - The existing forwarding unit reuses these.
- One natural sub-module: md_busy_counter (load/decrement/busy).
- Hazard compare logic stays flat in stall_control.

Test Plan:
- Load-use: IR_E=0x8E080000 (lw $8), IR_D=0x01084820 (add $9,$8,$8) -> stall=1. Next cycle IR_E=0, IR_M=0x8E080000 -> stall=0; stall_cycles=1.
- Store data: IR_E=0x8E080000, IR_D=0xAE080000 (sw $8,0($16)) -> stall=0 (rt Tuse 2). IR_D=0x8D080000 (lw $8,0($8)) -> stall=1.
- Branch: IR_E=0x00004021 (addu $8,$0,$0), IR_D=0x11000003 (beq $8,$0) -> stall=1. With IR_M=0x8E080000 and IR_E=0 -> stall=1. With IR_M=0x00004021 -> stall=0.
- Mult/div busy: IR_E=0x01090018 (mult) at cycle t, IR_D=0x00005012 (mflo $10) held.
  - Required: md_start=1 at t; md_busy=1 t+1..t+5; stall=1 t..t+5; stall=0 at t+6.
  - Same sequence with div (0x0109001A): stall=1 t..t+10.
- Reset mid-op: div loaded, rst_n=0 when counter=7 -> md_busy=0 and stall_cycles=0 immediately. After release, IR_D=mflo with IR_E=0 -> stall=0.
- $0 writer: IR_E=0x8E000000 (lw $0), IR_D=0x00004820 (add $9,$0,$0) -> stall=0. Also IR_D=0x00000000 under any IR_E -> stall=0.
